// File: rtl/iq_pkg.sv
// Shared types for the unified issue queue: op-type codes, the queue entry
// record and a lowest-set-bit helper used for free-slot allocation.
package iq_pkg;

    localparam int IQ_DATA_W = 32;
    localparam int IQ_PREG_W = 6;
    localparam int IQ_ROB_W  = 6;
    localparam int IQ_OP_W   = 4;
    localparam int IQ_FU_W   = 4;

    localparam logic [IQ_OP_W-1:0] OP_ADD  = 4'd1;
    localparam logic [IQ_OP_W-1:0] OP_ADDI = 4'd2;
    localparam logic [IQ_OP_W-1:0] OP_LUI  = 4'd3;
    localparam logic [IQ_OP_W-1:0] OP_ORI  = 4'd4;
    localparam logic [IQ_OP_W-1:0] OP_XOR  = 4'd5;
    localparam logic [IQ_OP_W-1:0] OP_SRAI = 4'd6;
    localparam logic [IQ_OP_W-1:0] OP_LB   = 4'd7;
    localparam logic [IQ_OP_W-1:0] OP_LW   = 4'd8;
    localparam logic [IQ_OP_W-1:0] OP_SB   = 4'd9;
    localparam logic [IQ_OP_W-1:0] OP_SW   = 4'd10;

    typedef struct packed {
        logic                 valid;
        logic [IQ_FU_W-1:0]   fu;
        logic [IQ_OP_W-1:0]   op;
        logic [IQ_DATA_W-1:0] pc;
        logic [IQ_DATA_W-1:0] imm;
        logic [IQ_PREG_W-1:0] dst;
        logic [IQ_ROB_W-1:0]  rob;
        logic [IQ_PREG_W-1:0] src1_tag;
        logic                 src1_rdy;
        logic [IQ_DATA_W-1:0] src1_data;
        logic [IQ_PREG_W-1:0] src2_tag;
        logic                 src2_rdy;
        logic [IQ_DATA_W-1:0] src2_data;
    } iq_entry_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [5:0] lowest_set_idx(input logic [63:0] vec);
        logic [5:0] idx;
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i]) idx = 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// Relative-age tracker: older[i][j] set means entry i was allocated before j.
// Grants the oldest entry of a request vector as a one-hot.
module iq_age_matrix #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant
);

    logic [DEPTH-1:0] older [DEPTH];

    // A new entry is younger than every live entry; the diagonal stays 0
    // because an allocated slot is never valid in its allocation cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (free[i] || free[j])
                        older[i][j] <= 1'b0;
                    else if (alloc[j])
                        older[i][j] <= valid[i];
                    else if (alloc[i])
                        older[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        grant = req;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (req[j] && older[j][i]) grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/issue_queue_param.sv
// Unified issue queue: buffers renamed micro-ops, wakes operands from writeback
// buses and issues the oldest ready entry per FU. Optional: IQ_WAKEUP_BYPASS_EN.
module issue_queue_param
    import iq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NUM_FU = 3,
    parameter int NUM_WB = 2,
    parameter int DATA_W = IQ_DATA_W,
    parameter int PREG_W = IQ_PREG_W,
    parameter int ROB_W  = IQ_ROB_W,
    parameter int OP_W   = IQ_OP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [DATA_W-1:0]        disp_pc,
    input  logic [OP_W-1:0]          disp_op,
    input  logic [DATA_W-1:0]        disp_imm,
    input  logic [PREG_W-1:0]        disp_dst,
    input  logic [ROB_W-1:0]         disp_rob,
    input  logic [PREG_W-1:0]        disp_src1_tag,
    input  logic [PREG_W-1:0]        disp_src2_tag,
    input  logic                     disp_src1_rdy,
    input  logic                     disp_src2_rdy,
    input  logic [DATA_W-1:0]        disp_src1_data,
    input  logic [DATA_W-1:0]        disp_src2_data,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*PREG_W-1:0] wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    input  logic [NUM_FU-1:0]        fu_ready,
    output logic [NUM_FU-1:0]        iss_valid,
    output logic [NUM_FU*DATA_W-1:0] iss_pc,
    output logic [NUM_FU*DATA_W-1:0] iss_imm,
    output logic [NUM_FU*DATA_W-1:0] iss_src1,
    output logic [NUM_FU*DATA_W-1:0] iss_src2,
    output logic [NUM_FU*OP_W-1:0]   iss_op,
    output logic [NUM_FU*PREG_W-1:0] iss_dst,
    output logic [NUM_FU*ROB_W-1:0]  iss_rob,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t          ent [DEPTH];
    iq_entry_t          new_ent;
    logic [IQ_FU_W-1:0] rr_ptr;
    logic [PREG_W-1:0]  wb_tag_a  [NUM_WB];
    logic [DATA_W-1:0]  wb_data_a [NUM_WB];
    logic [DEPTH-1:0]   valid_vec, free_slots, free_vec, alloc_oh;
    logic [DEPTH-1:0]   s1_hit, s2_hit, s1_ok, s2_ok;
    logic [DATA_W-1:0]  s1_wb [DEPTH];
    logic [DATA_W-1:0]  s2_wb [DEPTH];
    logic               d1_hit, d2_hit;
    logic [DATA_W-1:0]  d1_wb, d2_wb;
    logic [DEPTH-1:0]   req   [NUM_FU];
    logic [DEPTH-1:0]   grant [NUM_FU];
    logic [NUM_FU-1:0]  sel_any;
    logic [DATA_W-1:0]  sel_pc [NUM_FU], sel_imm [NUM_FU], sel_s1 [NUM_FU], sel_s2 [NUM_FU];
    logic [OP_W-1:0]    sel_op  [NUM_FU];
    logic [PREG_W-1:0]  sel_dst [NUM_FU];
    logic [ROB_W-1:0]   sel_rob [NUM_FU];
    logic [CNT_W-1:0]   iss_cnt;
    logic [IDX_W-1:0]   alloc_idx;
    logic               disp_fire;

    // Dispatch handshake: a micro-op transfers on a cycle where disp_valid and
    // disp_ready are both high; disp_ready depends on registered occupancy only.
    assign disp_ready = occupancy < CNT_W'(DEPTH);
    assign disp_fire  = disp_valid && disp_ready && (disp_op != '0) && !flush;
    assign free_slots = ~valid_vec;
    assign alloc_idx  = IDX_W'(lowest_set_idx(64'(free_slots)));

    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            wb_tag_a[k]  = wb_tag[k*PREG_W +: PREG_W];
            wb_data_a[k] = wb_data[k*DATA_W +: DATA_W];
        end
    end

    // Tag match against every broadcast; scanning downwards lets the lowest bus win.
    always_comb begin
        s1_hit = '0;
        s2_hit = '0;
        d1_hit = 1'b0;
        d2_hit = 1'b0;
        d1_wb  = '0;
        d2_wb  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            s1_wb[i]     = '0;
            s2_wb[i]     = '0;
            valid_vec[i] = ent[i].valid;
            alloc_oh[i]  = disp_fire && (alloc_idx == IDX_W'(i));
        end
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_valid[k] && wb_tag_a[k] == ent[i].src1_tag) begin
                    s1_hit[i] = 1'b1;
                    s1_wb[i]  = wb_data_a[k];
                end
                if (wb_valid[k] && wb_tag_a[k] == ent[i].src2_tag) begin
                    s2_hit[i] = 1'b1;
                    s2_wb[i]  = wb_data_a[k];
                end
            end
            if (wb_valid[k] && wb_tag_a[k] == disp_src1_tag) begin
                d1_hit = 1'b1;
                d1_wb  = wb_data_a[k];
            end
            if (wb_valid[k] && wb_tag_a[k] == disp_src2_tag) begin
                d2_hit = 1'b1;
                d2_wb  = wb_data_a[k];
            end
        end
    end

    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.fu        = rr_ptr;
        new_ent.op        = disp_op;
        new_ent.pc        = disp_pc;
        new_ent.imm       = disp_imm;
        new_ent.dst       = disp_dst;
        new_ent.rob       = disp_rob;
        new_ent.src1_tag  = disp_src1_tag;
        new_ent.src1_rdy  = disp_src1_rdy || d1_hit;
        new_ent.src1_data = disp_src1_rdy ? disp_src1_data : d1_wb;
        new_ent.src2_tag  = disp_src2_tag;
        new_ent.src2_rdy  = disp_src2_rdy || d2_hit;
        new_ent.src2_data = disp_src2_rdy ? disp_src2_data : d2_wb;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef IQ_WAKEUP_BYPASS_EN
            s1_ok[i] = ent[i].src1_rdy || s1_hit[i];
            s2_ok[i] = ent[i].src2_rdy || s2_hit[i];
`else
            s1_ok[i] = ent[i].src1_rdy;
            s2_ok[i] = ent[i].src2_rdy;
`endif
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            req[f] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                req[f][i] = ent[i].valid && fu_ready[f] && (ent[i].fu == IQ_FU_W'(f))
                            && s1_ok[i] && s2_ok[i];
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_age
        iq_age_matrix #(.DEPTH(DEPTH)) u_age (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .valid (valid_vec),
            .alloc (alloc_oh),
            .free  (free_vec),
            .req   (req[f]),
            .grant (grant[f])
        );
    end

    always_comb begin
        free_vec = '0;
        iss_cnt  = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            sel_any[f] = |grant[f];
            free_vec   = free_vec | grant[f];
            iss_cnt    = iss_cnt + CNT_W'(sel_any[f]);
            sel_pc[f]  = '0;
            sel_imm[f] = '0;
            sel_op[f]  = '0;
            sel_dst[f] = '0;
            sel_rob[f] = '0;
            sel_s1[f]  = '0;
            sel_s2[f]  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[f][i]) begin
                    sel_pc[f]  = ent[i].pc;
                    sel_imm[f] = ent[i].imm;
                    sel_op[f]  = ent[i].op;
                    sel_dst[f] = ent[i].dst;
                    sel_rob[f] = ent[i].rob;
`ifdef IQ_WAKEUP_BYPASS_EN
                    sel_s1[f]  = ent[i].src1_rdy ? ent[i].src1_data : s1_wb[i];
                    sel_s2[f]  = ent[i].src2_rdy ? ent[i].src2_data : s2_wb[i];
`else
                    sel_s1[f]  = ent[i].src1_data;
                    sel_s2[f]  = ent[i].src2_data;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            rr_ptr    <= '0;
            occupancy <= '0;
            iss_valid <= '0;
            iss_pc    <= '0;
            iss_imm   <= '0;
            iss_src1  <= '0;
            iss_src2  <= '0;
            iss_op    <= '0;
            iss_dst   <= '0;
            iss_rob   <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
            occupancy <= '0;
            iss_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent[i].valid && !ent[i].src1_rdy && s1_hit[i]) begin
                    ent[i].src1_rdy  <= 1'b1;
                    ent[i].src1_data <= s1_wb[i];
                end
                if (ent[i].valid && !ent[i].src2_rdy && s2_hit[i]) begin
                    ent[i].src2_rdy  <= 1'b1;
                    ent[i].src2_data <= s2_wb[i];
                end
                if (free_vec[i]) ent[i].valid <= 1'b0;
                if (alloc_oh[i]) ent[i] <= new_ent;
            end
            if (disp_fire)
                rr_ptr <= (rr_ptr == IQ_FU_W'(NUM_FU - 1)) ? '0 : rr_ptr + 1'b1;
            occupancy <= occupancy + CNT_W'(disp_fire) - iss_cnt;
            iss_valid <= sel_any;
            for (int f = 0; f < NUM_FU; f++) begin
                if (sel_any[f]) begin
                    iss_pc[f*DATA_W +: DATA_W]   <= sel_pc[f];
                    iss_imm[f*DATA_W +: DATA_W]  <= sel_imm[f];
                    iss_src1[f*DATA_W +: DATA_W] <= sel_s1[f];
                    iss_src2[f*DATA_W +: DATA_W] <= sel_s2[f];
                    iss_op[f*OP_W +: OP_W]       <= sel_op[f];
                    iss_dst[f*PREG_W +: PREG_W]  <= sel_dst[f];
                    iss_rob[f*ROB_W +: ROB_W]    <= sel_rob[f];
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_param.sv
// Directed bench for issue_queue_param (DEPTH=4, NUM_FU=3, NUM_WB=2): issue
// records are queued at dispatch and matched per FU in issue order.
module tb_issue_queue_param;
    import iq_pkg::*;

    localparam int DEPTH = 4, NUM_FU = 3, NUM_WB = 2;
    localparam int DW = 32, PW = 6, RW = 6, OW = 4, EW = 76;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic                 disp_valid = 1'b0;
    logic                 disp_ready;
    logic [DW-1:0]        disp_pc = '0, disp_imm = '0;
    logic [OW-1:0]        disp_op = '0;
    logic [PW-1:0]        disp_dst = '0;
    logic [RW-1:0]        disp_rob = '0;
    logic [PW-1:0]        disp_src1_tag = '0, disp_src2_tag = '0;
    logic                 disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
    logic [DW-1:0]        disp_src1_data = '0, disp_src2_data = '0;
    logic [NUM_WB-1:0]    wb_valid = '0;
    logic [NUM_WB*PW-1:0] wb_tag = '0;
    logic [NUM_WB*DW-1:0] wb_data = '0;
    logic [NUM_FU-1:0]    fu_ready = '0;
    logic [NUM_FU-1:0]    iss_valid;
    logic [NUM_FU*DW-1:0] iss_pc, iss_imm, iss_src1, iss_src2;
    logic [NUM_FU*OW-1:0] iss_op;
    logic [NUM_FU*PW-1:0] iss_dst;
    logic [NUM_FU*RW-1:0] iss_rob;
    logic [2:0]           occupancy;

    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            passed = 0;
    int            rr = 0;

    issue_queue_param #(
        .DEPTH(DEPTH), .NUM_FU(NUM_FU), .NUM_WB(NUM_WB),
        .DATA_W(DW), .PREG_W(PW), .ROB_W(RW), .OP_W(OW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_pc(disp_pc), .disp_op(disp_op), .disp_imm(disp_imm),
        .disp_dst(disp_dst), .disp_rob(disp_rob),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_data(disp_src1_data), .disp_src2_data(disp_src2_data),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .fu_ready(fu_ready), .iss_valid(iss_valid),
        .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_src1(iss_src1), .iss_src2(iss_src2),
        .iss_op(iss_op), .iss_dst(iss_dst), .iss_rob(iss_rob),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic disp(input logic [OW-1:0] op, input logic [RW-1:0] rob,
                        input logic [PW-1:0] t1, input logic r1, input logic [DW-1:0] d1,
                        input logic [PW-1:0] t2, input logic r2, input logic [DW-1:0] d2);
        disp_valid = 1'b1;
        disp_op = op;
        disp_rob = rob;
        disp_pc = 32'h100 + 32'(rob);
        disp_imm = 32'(rob) * 2;
        disp_dst = rob + 6'd1;
        disp_src1_tag = t1; disp_src1_rdy = r1; disp_src1_data = d1;
        disp_src2_tag = t2; disp_src2_rdy = r2; disp_src2_data = d2;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
    endtask

    // Bench-side FU binding: round robin over accepted dispatches only.
    task automatic accept(input logic [OW-1:0] op, input logic [RW-1:0] rob,
                          input logic [DW-1:0] s1, input logic [DW-1:0] s2, input bit push);
        if (push) exp_q.push_back({2'(rr), op, rob, s1, s2});
        rr = (rr == NUM_FU - 1) ? 0 : rr + 1;
    endtask

    task automatic bcast(input logic [1:0] v, input logic [PW-1:0] t0, input logic [DW-1:0] d0,
                         input logic [PW-1:0] t1, input logic [DW-1:0] d1);
        wb_valid = v;
        wb_tag = {t1, t0};
        wb_data = {d1, d0};
    endtask

    task automatic step(input logic [NUM_FU-1:0] exp_iv, input int exp_occ);
        int idx;
        logic [EW-1:0] got;
        @(posedge clk);
        #1;
        check("iss_valid", iss_valid, exp_iv);
        check("occupancy", occupancy, exp_occ);
        check("disp_ready", disp_ready, exp_occ < DEPTH);
        for (int f = 0; f < NUM_FU; f++) begin
            if (iss_valid[f]) begin
                idx = -1;
                for (int j = 0; j < exp_q.size(); j++)
                    if (idx < 0 && exp_q[j][EW-1 -: 2] == 2'(f)) idx = j;
                got = {2'(f), iss_op[f*OW +: OW], iss_rob[f*RW +: RW],
                       iss_src1[f*DW +: DW], iss_src2[f*DW +: DW]};
                checks++;
                assert (idx >= 0) passed++;
                else $error("FAIL issue_unexpected: port %0d got %0h expected none", f, got);
                if (idx >= 0) begin
                    check("issue_record", got, exp_q[idx]);
                    exp_q.delete(idx);
                end
            end
        end
    endtask

    initial begin
        logic [DW-1:0] ra [6];
        for (int i = 0; i < 6; i++) ra[i] = 32'($urandom_range(1, 32'hFFFF));

        fu_ready = 3'b111;
        step(3'b000, 0);
        step(3'b000, 0);
        rst = 1'b0;
        check("rst_iss_pc", iss_pc, '0);
        check("rst_iss_rob", iss_rob, '0);

        // op 0 is dropped
        disp(4'd0, 6'd1, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
        step(3'b000, 0);
        idle();
        step(3'b000, 0);

        // ready ADD issues one edge after dispatch
        disp(OP_ADD, 6'd3, 6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7);
        accept(OP_ADD, 6'd3, 32'd5, 32'd7, 1'b1);
        step(3'b000, 1);
        idle();
        step(3'b001, 0);
        check("t1_pc", iss_pc[31:0], 32'h103);
        check("t1_imm", iss_imm[31:0], 32'd6);
        check("t1_dst", iss_dst[5:0], 6'd4);
        step(3'b000, 0);
        check("t1_hold_rob", iss_rob[5:0], 6'd3);

        // wakeup on tag 12; both buses match, bus 0 wins
        disp(OP_ADD, 6'd4, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd9);
        accept(OP_ADD, 6'd4, 32'h55, 32'd9, 1'b1);
        step(3'b000, 1);
        idle();
        step(3'b000, 1);
        bcast(2'b11, 6'd12, 32'h55, 6'd12, 32'h66);
`ifdef IQ_WAKEUP_BYPASS_EN
        step(3'b010, 0);
        bcast(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step(3'b000, 0);
`else
        step(3'b000, 1);
        bcast(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step(3'b010, 0);
`endif

        // fill to DEPTH with FUs stalled, refuse a fifth, then drain
        fu_ready = 3'b000;
        for (int n = 0; n < 4; n++) begin
            disp(OP_ADD, 6'(10 + n), 6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'(n));
            accept(OP_ADD, 6'(10 + n), 32'h20, 32'(n), 1'b1);
            step(3'b000, n + 1);
        end
        disp(OP_ADD, 6'd14, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
        step(3'b000, 4);
        idle();
        bcast(2'b01, 6'd20, 32'h20, 6'd0, 32'd0);
        step(3'b000, 4);
        bcast(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        fu_ready = 3'b111;
        step(3'b111, 1);
        step(3'b100, 0);
        check("drain_empty", exp_q.size(), 0);

        // A and B share FU 0 and wake together: A first, then B
        disp(OP_ADD, 6'd20, 6'd30, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1);
        accept(OP_ADD, 6'd20, 32'hAA, 32'd1, 1'b1);
        step(3'b000, 1);
        disp(OP_XOR, 6'd21, 6'd31, 1'b0, 32'd0, 6'd0, 1'b1, 32'd2);
        accept(OP_XOR, 6'd21, 32'hBB, 32'd2, 1'b1);
        step(3'b000, 2);
        disp(OP_XOR, 6'd22, 6'd31, 1'b0, 32'd0, 6'd0, 1'b1, 32'd3);
        accept(OP_XOR, 6'd22, 32'hBB, 32'd3, 1'b1);
        step(3'b000, 3);
        disp(OP_ADD, 6'd23, 6'd30, 1'b0, 32'd0, 6'd0, 1'b1, 32'd4);
        accept(OP_ADD, 6'd23, 32'hAA, 32'd4, 1'b1);
        step(3'b000, 4);
        idle();
        bcast(2'b10, 6'd0, 32'd0, 6'd30, 32'hAA);
`ifdef IQ_WAKEUP_BYPASS_EN
        step(3'b001, 3);
        bcast(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step(3'b001, 2);
        bcast(2'b01, 6'd31, 32'hBB, 6'd0, 32'd0);
        step(3'b110, 0);
        bcast(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step(3'b000, 0);
`else
        step(3'b000, 4);
        bcast(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step(3'b001, 3);
        step(3'b001, 2);
        bcast(2'b01, 6'd31, 32'hBB, 6'd0, 32'd0);
        step(3'b000, 2);
        bcast(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step(3'b110, 0);
`endif

        // flush with three waiting entries and a same-cycle dispatch
        for (int n = 0; n < 3; n++) begin
            disp(OP_ADD, 6'(30 + n), 6'd40, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0);
            accept(OP_ADD, 6'(30 + n), 32'd0, 32'd0, 1'b0);
            step(3'b000, n + 1);
        end
        disp(OP_ADD, 6'd33, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
        flush = 1'b1;
        step(3'b000, 0);
        flush = 1'b0;
        idle();
        bcast(2'b01, 6'd40, 32'h40, 6'd0, 32'd0);
        step(3'b000, 0);
        bcast(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step(3'b000, 0);
        step(3'b000, 0);
        disp(OP_ADD, 6'd34, 6'd0, 1'b1, 32'h34, 6'd0, 1'b1, 32'h35);
        accept(OP_ADD, 6'd34, 32'h34, 32'h35, 1'b1);
        step(3'b000, 1);
        idle();
        step(3'b010, 0);

        // reset pulse mid-operation
        for (int n = 0; n < 2; n++) begin
            disp(OP_ADD, 6'(35 + n), 6'd41, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0);
            accept(OP_ADD, 6'(35 + n), 32'd0, 32'd0, 1'b0);
            step(3'b000, n + 1);
        end
        idle();
        rst = 1'b1;
        step(3'b000, 0);
        rst = 1'b0;
        rr = 0;
        check("rst2_iss_rob", iss_rob, '0);
        check("rst2_iss_src1", iss_src1, '0);
        bcast(2'b01, 6'd41, 32'h41, 6'd0, 32'd0);
        step(3'b000, 0);
        bcast(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step(3'b000, 0);

        // three ready ops back-to-back land on FU 0, 1, 2
        disp(OP_ADDI, 6'd50, 6'd0, 1'b1, ra[0], 6'd0, 1'b1, ra[1]);
        accept(OP_ADDI, 6'd50, ra[0], ra[1], 1'b1);
        step(3'b000, 1);
        disp(OP_LW, 6'd51, 6'd0, 1'b1, ra[2], 6'd0, 1'b1, ra[3]);
        accept(OP_LW, 6'd51, ra[2], ra[3], 1'b1);
        step(3'b001, 1);
        disp(OP_SW, 6'd52, 6'd0, 1'b1, ra[4], 6'd0, 1'b1, ra[5]);
        accept(OP_SW, 6'd52, ra[4], ra[5], 1'b1);
        step(3'b010, 1);
        idle();
        step(3'b100, 0);
        check("final_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
